// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retirement, writeback capture, operand lookup, flush on mispredicted branch commit.
// Optional macro ROB_CDB_BYPASS_EN: lookups also see the writeback bus in the same cycle.
module reorder_buffer #(
  parameter int ROB_BIT = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  input  logic               issue_is_br,
  output logic [ROB_BIT-1:0] issue_rob_entry,
  output logic               rob_full,
  output logic               debug_rob_empty,
  input  logic               wb_valid,
  input  logic [ROB_BIT-1:0] wb_entry,
  input  logic [31:0]        wb_value,
  input  logic               wb_mispredict,
  input  logic [31:0]        wb_target,
  output logic               rob_commit,
  output logic [4:0]         commit_reg_id,
  output logic [31:0]        commit_reg_data,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               rob_clear_up,
  output logic [31:0]        clear_pc,
  input  logic [ROB_BIT-1:0] get_rob_entry1,
  input  logic [ROB_BIT-1:0] get_rob_entry2,
  output logic               ready1,
  output logic               ready2,
  output logic [31:0]        value1,
  output logic [31:0]        value2
);

  localparam int unsigned      DEPTH   = 1 << ROB_BIT;
  localparam logic [ROB_BIT:0] L_DEPTH = {1'b1, {ROB_BIT{1'b0}}};

  logic [DEPTH-1:0]   r_busy;
  logic [DEPTH-1:0]   r_ready;
  logic [DEPTH-1:0]   r_is_br;
  logic [DEPTH-1:0]   r_mis;
  logic [4:0]         r_rd     [DEPTH];
  logic [31:0]        r_value  [DEPTH];
  logic [31:0]        r_target [DEPTH];
  logic [ROB_BIT-1:0] r_head;
  logic [ROB_BIT-1:0] r_tail;
  logic [ROB_BIT:0]   r_count;

  logic               r_commit;
  logic [4:0]         r_commit_rd;
  logic [31:0]        r_commit_data;
  logic [ROB_BIT-1:0] r_commit_entry;
  logic               r_clear_up;
  logic [31:0]        r_clear_pc;

  logic w_full;
  logic w_commit;
  logic w_flush;
  logic w_issue;
  logic w_wb;

  assign w_full   = (r_count == L_DEPTH);
  assign w_commit = r_busy[r_head] & r_ready[r_head];
  assign w_flush  = w_commit & r_mis[r_head];
  // When full, the slot retiring this cycle is the tail, so issue proceeds alongside the commit.
  assign w_issue  = issue_valid & ~r_clear_up & (~w_full | w_commit);
  assign w_wb     = wb_valid & ~r_clear_up & r_busy[wb_entry];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy         <= '0;
      r_ready        <= '0;
      r_is_br        <= '0;
      r_mis          <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rd[i]     <= '0;
        r_value[i]  <= '0;
        r_target[i] <= '0;
      end
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_commit       <= 1'b0;
      r_commit_rd    <= '0;
      r_commit_data  <= '0;
      r_commit_entry <= '0;
      r_clear_up     <= 1'b0;
      r_clear_pc     <= '0;
    end else if (!rdy_in) begin
      r_commit   <= 1'b0;
      r_clear_up <= 1'b0;
    end else begin
      r_commit   <= w_commit;
      r_clear_up <= w_flush;
      if (w_commit) begin
        r_commit_rd    <= r_rd[r_head];
        r_commit_data  <= r_value[r_head];
        r_commit_entry <= r_head;
      end
      if (w_flush) begin
        r_clear_pc <= r_target[r_head];
        r_busy     <= '0;
        r_ready    <= '0;
        r_mis      <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
      end else begin
        if (w_commit) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + ROB_BIT'(1);
        end
        if (w_wb) begin
          r_ready[wb_entry]  <= 1'b1;
          r_value[wb_entry]  <= wb_value;
          // Only branch entries can redirect fetch.
          r_mis[wb_entry]    <= wb_mispredict & r_is_br[wb_entry];
          r_target[wb_entry] <= wb_target;
        end
        if (w_issue) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= 1'b0;
          r_is_br[r_tail] <= issue_is_br;
          r_mis[r_tail]   <= 1'b0;
          r_rd[r_tail]    <= issue_rd;
          r_tail          <= r_tail + ROB_BIT'(1);
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_comb begin
    ready1 = r_busy[get_rob_entry1] & r_ready[get_rob_entry1];
    value1 = ready1 ? r_value[get_rob_entry1] : '0;
    ready2 = r_busy[get_rob_entry2] & r_ready[get_rob_entry2];
    value2 = ready2 ? r_value[get_rob_entry2] : '0;
`ifdef ROB_CDB_BYPASS_EN
    if (wb_valid && !r_clear_up && wb_entry == get_rob_entry1 && r_busy[get_rob_entry1]) begin
      ready1 = 1'b1;
      value1 = wb_value;
    end
    if (wb_valid && !r_clear_up && wb_entry == get_rob_entry2 && r_busy[get_rob_entry2]) begin
      ready2 = 1'b1;
      value2 = wb_value;
    end
`endif
  end

  assign issue_rob_entry  = r_tail;
  assign rob_full         = w_full;
  assign debug_rob_empty  = (r_count == '0);
  assign rob_commit       = r_commit;
  assign commit_reg_id    = r_commit_rd;
  assign commit_reg_data  = r_commit_data;
  assign commit_rob_entry = r_commit_entry;
  assign rob_clear_up     = r_clear_up;
  assign clear_pc         = r_clear_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios with literal expectations plus random traffic against a queue model.
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid, issue_is_br;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_rob_entry;
  logic        rob_full, debug_rob_empty;
  logic        wb_valid, wb_mispredict;
  logic [2:0]  wb_entry;
  logic [31:0] wb_value, wb_target;
  logic        rob_commit, rob_clear_up;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_reg_data, clear_pc;
  logic [2:0]  commit_rob_entry;
  logic [2:0]  get_rob_entry1, get_rob_entry2;
  logic        ready1, ready2;
  logic [31:0] value1, value2;

  int checks = 0;
  int failures = 0;

  reorder_buffer #(.ROB_BIT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
    .issue_rob_entry(issue_rob_entry), .rob_full(rob_full), .debug_rob_empty(debug_rob_empty),
    .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .rob_commit(rob_commit), .commit_reg_id(commit_reg_id), .commit_reg_data(commit_reg_data),
    .commit_rob_entry(commit_rob_entry), .rob_clear_up(rob_clear_up), .clear_pc(clear_pc),
    .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
    .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: live entries kept in program order in a queue.
  typedef struct {
    int          idx;
    logic [4:0]  rd;
    bit          br;
    bit          rdy;
    logic [31:0] val;
    bit          mis;
    logic [31:0] tgt;
  } ent_t;

  ent_t        q[$];
  int          m_tail = 0;
  bit          e_commit = 0, e_clear = 0;
  logic [4:0]  e_reg = '0;
  logic [31:0] e_data = '0, e_pc = '0;
  int          e_ent = 0;

  function automatic int find(input int idx);
    for (int i = 0; i < q.size(); i++)
      if (q[i].idx == idx) return i;
    return -1;
  endfunction

  function automatic void look(input int e, output bit r, output logic [31:0] v);
    int p;
    p = find(e);
    r = (p >= 0) && q[p].rdy;
    v = r ? q[p].val : 32'h0;
`ifdef ROB_CDB_BYPASS_EN
    if (wb_valid && !e_clear && int'(wb_entry) == e && p >= 0) begin
      r = 1'b1;
      v = wb_value;
    end
`endif
  endfunction

  always @(posedge clk_in) begin
    bit   flushing, can_c, iss;
    int   wp;
    ent_t ne;
    if (rst_in) begin
      q.delete();
      m_tail = 0; e_commit = 0; e_clear = 0;
      e_reg = '0; e_data = '0; e_ent = 0; e_pc = '0;
    end else if (!rdy_in) begin
      e_commit = 0;
      e_clear  = 0;
    end else begin
      flushing = e_clear;
      can_c    = (q.size() > 0) && q[0].rdy;
      iss      = issue_valid && !flushing && (q.size() < 8 || can_c);
      wp       = (wb_valid && !flushing) ? find(int'(wb_entry)) : -1;
      e_commit = can_c;
      e_clear  = can_c && q[0].mis;
      if (can_c) begin
        e_reg = q[0].rd; e_data = q[0].val; e_ent = q[0].idx;
      end
      if (e_clear) begin
        e_pc = q[0].tgt;
        q.delete();
        m_tail = 0;
      end else begin
        if (wp >= 0) begin
          q[wp].rdy = 1; q[wp].val = wb_value; q[wp].mis = wb_mispredict; q[wp].tgt = wb_target;
        end
        if (can_c) void'(q.pop_front());
        if (iss) begin
          ne.idx = m_tail; ne.rd = issue_rd; ne.br = issue_is_br;
          ne.rdy = 0; ne.val = '0; ne.mis = 0; ne.tgt = '0;
          q.push_back(ne);
          m_tail = (m_tail + 1) % 8;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    bit          r;
    logic [31:0] v;
    chk("m_tail", issue_rob_entry, m_tail);
    chk("m_full", rob_full, q.size() == 8);
    chk("m_empty", debug_rob_empty, q.size() == 0);
    chk("m_commit", rob_commit, e_commit);
    chk("m_creg", commit_reg_id, e_reg);
    chk("m_cdata", commit_reg_data, e_data);
    chk("m_cent", commit_rob_entry, e_ent);
    chk("m_clear", rob_clear_up, e_clear);
    chk("m_cpc", clear_pc, e_pc);
    look(int'(get_rob_entry1), r, v);
    chk("m_ready1", ready1, r);
    chk("m_value1", value1, v);
    look(int'(get_rob_entry2), r, v);
    chk("m_ready2", ready2, r);
    chk("m_value2", value2, v);
  end

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  initial begin
    int p;
    rst_in = 1; rdy_in = 1; issue_valid = 0; issue_rd = '0; issue_is_br = 0;
    wb_valid = 0; wb_entry = '0; wb_value = '0; wb_mispredict = 0; wb_target = '0;
    get_rob_entry1 = '0; get_rob_entry2 = '0;
    repeat (2) step();
    rst_in = 0;
    #1;
    chk("rst_empty", debug_rob_empty, 1);
    chk("rst_commit", rob_commit, 0);
    chk("rst_clear", rob_clear_up, 0);
    chk("rst_tail", issue_rob_entry, 0);

    for (int i = 0; i < 8; i++) begin
      issue_valid = 1; issue_rd = 5'(i + 1); issue_is_br = (i == 2);
      #1 chk("fill_idx", issue_rob_entry, i);
      step();
    end
    chk("fill_full", rob_full, 1);
    issue_rd = 5'd9; issue_is_br = 0;
    step();
    issue_valid = 0;
    chk("drop_tail", issue_rob_entry, 0);
    chk("drop_full", rob_full, 1);

    wb_valid = 1; wb_entry = 3'd1; wb_value = 32'h22;
    step();
    wb_entry = 3'd0; wb_value = 32'h11;
    step();
    wb_valid = 0; issue_valid = 1; issue_rd = 5'd10;
    step();
    issue_valid = 0;
    chk("c0_commit", rob_commit, 1);
    chk("c0_reg", commit_reg_id, 1);
    chk("c0_data", commit_reg_data, 32'h11);
    chk("c0_ent", commit_rob_entry, 0);
    chk("c0_full", rob_full, 1);
    chk("c0_tail", issue_rob_entry, 1);
    step();
    chk("c1_commit", rob_commit, 1);
    chk("c1_reg", commit_reg_id, 2);
    chk("c1_data", commit_reg_data, 32'h22);
    chk("c1_ent", commit_rob_entry, 1);
    chk("c1_full", rob_full, 0);

    wb_valid = 1; wb_entry = 3'd2; wb_value = 32'h33; wb_mispredict = 1; wb_target = 32'h1000;
    step();
    wb_valid = 0; wb_mispredict = 0;
    step();
    chk("br_commit", rob_commit, 1);
    chk("br_clear", rob_clear_up, 1);
    chk("br_pc", clear_pc, 32'h1000);
    chk("br_reg", commit_reg_id, 3);
    chk("br_ent", commit_rob_entry, 2);
    chk("br_empty", debug_rob_empty, 1);
    chk("br_tail", issue_rob_entry, 0);
    issue_valid = 1; issue_rd = 5'd5; wb_valid = 1; wb_entry = 3'd0;
    step();
    issue_valid = 0; wb_valid = 0;
    chk("fl_clear", rob_clear_up, 0);
    chk("fl_empty", debug_rob_empty, 1);
    chk("fl_tail", issue_rob_entry, 0);

    for (int i = 0; i < 4; i++) begin
      issue_valid = 1; issue_rd = 5'(11 + i);
      step();
    end
    issue_valid = 0;
    wb_valid = 1; wb_entry = 3'd3; wb_value = 32'h55; get_rob_entry1 = 3'd3;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("lk_same_rdy", ready1, 1);
    chk("lk_same_val", value1, 32'h55);
`else
    chk("lk_same_rdy", ready1, 0);
    chk("lk_same_val", value1, 0);
`endif
    step();
    wb_valid = 0;
    #1;
    chk("lk_next_rdy", ready1, 1);
    chk("lk_next_val", value1, 32'h55);

    wb_valid = 1; wb_entry = 3'd0; wb_value = 32'h77;
    step();
    wb_valid = 0; rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_commit", rob_commit, 0);
      chk("stall_tail", issue_rob_entry, 4);
    end
    rdy_in = 1;
    step();
    chk("rel_commit", rob_commit, 1);
    chk("rel_ent", commit_rob_entry, 0);
    chk("rel_data", commit_reg_data, 32'h77);
    chk("rel_reg", commit_reg_id, 11);

    for (int n = 0; n < 4000; n++) begin
      rst_in      = ($urandom_range(0, 399) == 0);
      rdy_in      = ($urandom_range(0, 9) != 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom);
      issue_is_br = ($urandom_range(0, 3) == 0);
      wb_valid    = $urandom_range(0, 1);
      wb_value    = $urandom;
      wb_target   = $urandom;
      if (q.size() > 0 && $urandom_range(0, 9) < 7)
        wb_entry = 3'(q[$urandom_range(0, q.size() - 1)].idx);
      else
        wb_entry = 3'($urandom);
      p = find(int'(wb_entry));
      wb_mispredict = (p >= 0) && q[p].br && ($urandom_range(0, 3) == 0);
      get_rob_entry1 = 3'($urandom);
      get_rob_entry2 = 3'($urandom);
      step();
    end
    rst_in = 0; rdy_in = 1; issue_valid = 0; wb_valid = 0;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
